// File: rtl/increment_pkg.sv
// Shared constants and data-word type for the registered incrementer.
package increment_pkg;

   // Default operand width and lookahead slice width.
   localparam int DEFAULT_WIDTH = 20;
   localparam int DEFAULT_SLICE = 4;

   // Data word at the default width.
   typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : increment_pkg

// File: rtl/increment_slice.sv
// One lookahead slice: adds the slice carry-in to its bits and reports
// whether the whole slice would pass a carry through (group propagate).
module increment_slice
   import increment_pkg::*;
#(
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic [SLICE-1:0] operand,
   input  logic             carry_in,
   output logic [SLICE-1:0] sum,
   output logic             group_prop
);

   // prefix[i] is carry_in AND all slice bits below bit i; a bit flips only
   // when every bit beneath it (and the slice carry-in) is one.
   logic [SLICE:0] prefix;

   assign prefix[0] = carry_in;

   generate
      for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
         assign prefix[gi+1] = prefix[gi] & operand[gi];
         assign sum[gi]      = operand[gi] ^ prefix[gi];
      end
   endgenerate

   // Propagate depends only on the slice's own bits, so the top-level
   // lookahead does not wait on this slice's carry-in.
   assign group_prop = &operand;

endmodule : increment_slice

// File: rtl/increment.sv
// Registered incrementer: out <= in + 1 (mod 2^WIDTH), carry_out flags an
// all-ones operand. Carries between slices come from a lookahead network
// built from per-slice group propagates, never from a neighbour's carry.
module increment
   import increment_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             carry_out
);

   localparam int NUM_SLICES = WIDTH / SLICE;

   logic [NUM_SLICES-1:0] group_prop;
   logic [NUM_SLICES-1:0] slice_carry;
   logic [WIDTH-1:0]      out_next;
   logic                  carry_out_next;
   logic [WIDTH-1:0]      out_reg;
   logic                  carry_out_reg;

   generate
      for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
         // Slice 0 always receives the +1; higher slices receive a carry
         // exactly when every lower slice is all ones.
         if (gi == 0) begin : g_first
            assign slice_carry[gi] = 1'b1;
         end else begin : g_upper
            assign slice_carry[gi] = &group_prop[gi-1:0];
         end

         increment_slice #(
            .SLICE (SLICE)
         ) u_slice (
            .operand    (in[gi*SLICE +: SLICE]),
            .carry_in   (slice_carry[gi]),
            .sum        (out_next[gi*SLICE +: SLICE]),
            .group_prop (group_prop[gi])
         );
      end
   endgenerate

   // The carry leaves the MSB only for an all-ones operand.
   assign carry_out_next = &group_prop;

   // Output registers; reset discards whatever operand is sampled that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg       <= '0;
         carry_out_reg <= 1'b0;
      end else begin
         out_reg       <= out_next;
         carry_out_reg <= carry_out_next;
      end
   end

   assign out       = out_reg;
   assign carry_out = carry_out_reg;

endmodule : increment

// File: tb/tb_increment.sv
// Directed and random checks of the registered incrementer against an
// arithmetic reference model: expected = rst ? 0 : in + 1 in WIDTH+1 bits.
module tb_increment;
   import increment_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_val;
   logic [W-1:0] out;
   logic         carry_out;

   int total;
   int bad;

   increment #(
      .WIDTH (W),
      .SLICE (DEFAULT_SLICE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_val),
      .out       (out),
      .carry_out (carry_out)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s out observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s carry_out observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Apply one operand for one edge, then compare both outputs with the model.
   task automatic step(input logic [W-1:0] v, input logic r, input string tag);
      logic [W:0] full;
      word_t      exp_out;
      logic       exp_carry;
      in_val = v;
      rst    = r;
      @(posedge clk);
      #1;
      full      = r ? '0 : ({1'b0, v} + (W+1)'(1));
      exp_out   = full[W-1:0];
      exp_carry = full[W];
      $display("step %-10s rst=%b in=%h out=%h carry_out=%b", tag, r, v, out, carry_out);
      check_word(tag, out, exp_out);
      check_bit(tag, carry_out, exp_carry);
   endtask

   initial begin
      logic [W-1:0] rnd;
      int unsigned  seed_val;
      logic [W-1:0] held_out;
      logic         held_carry;

      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      in_val = 20'h12345;
      @(posedge clk);

      // Reset with a nonzero operand present.
      step(20'h12345, 1'b1, "reset");

      // Directed operands, including slice boundaries and wrap-around.
      step(20'h00000, 1'b0, "zero");
      step(20'h0FFFF, 1'b0, "0ffff");
      step(20'h7FFFF, 1'b0, "7ffff");
      step(20'hFFFFF, 1'b0, "wrap");
      step(20'hFFFFE, 1'b0, "fffffe");
      step(20'h0000F, 1'b0, "slice1");
      step(20'h000FF, 1'b0, "slice2");
      step(20'h00FFF, 1'b0, "slice3");
      step(20'h0FFF0, 1'b0, "no_lsb");

      // A reset pulse between edges must leave the registers untouched.
      held_out   = out;
      held_carry = carry_out;
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      $display("step %-10s out=%h carry_out=%b", "midpulse", out, carry_out);
      check_word("midpulse", out, held_out);
      check_bit("midpulse", carry_out, held_carry);

      // Ten random operands back to back.
      seed_val = $urandom(48377);
      for (int i = 0; i < 10; i++) begin
         rnd = W'($urandom());
         step(rnd, 1'b0, $sformatf("rand%0d", i));
      end

      // Reset mid-stream drops that operand; increment resumes next edge.
      rnd = W'($urandom());
      step(rnd, 1'b0, "pre_rst");
      rnd = W'($urandom()) | 20'h00001;
      step(rnd, 1'b1, "mid_rst");
      rnd = W'($urandom());
      step(rnd, 1'b0, "resume");
      step(20'hFFFFF, 1'b0, "wrap2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_increment
